// File: rtl/address_generation_unit.sv
// Address generation unit: owns PC and SP, produces indexed, zero-page,
// branch and stack addresses, with an explicit page-crossing fix-up cycle.
module address_generation_unit #(
  parameter int                      DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]   STACK_PAGE = DATA_WIDTH'(1),
  parameter logic [2*DATA_WIDTH-1:0] PC_RESET   = '0,
  parameter logic [DATA_WIDTH-1:0]   SP_RESET   = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [2:0]                op_code,
  input  logic                      force_fix,
  input  logic [DATA_WIDTH-1:0]     base_low,
  input  logic [DATA_WIDTH-1:0]     base_high,
  input  logic [DATA_WIDTH-1:0]     index,
  input  logic [DATA_WIDTH-1:0]     offset,
  output logic                      partial_valid,
  output logic                      result_valid,
  output logic [2*DATA_WIDTH-1:0]   result_addr,
  output logic                      page_crossed,
  output logic                      illegal_op,
  output logic [2*DATA_WIDTH-1:0]   pc_out,
  output logic [DATA_WIDTH-1:0]     sp_out
);

  localparam int AW = 2 * DATA_WIDTH;

  localparam logic [2:0] OP_PC_INC     = 3'd0;
  localparam logic [2:0] OP_PC_LOAD    = 3'd1;
  localparam logic [2:0] OP_INDEXED    = 3'd2;
  localparam logic [2:0] OP_BRANCH     = 3'd3;
  localparam logic [2:0] OP_PUSH       = 3'd4;
  localparam logic [2:0] OP_POP        = 3'd5;
  localparam logic [2:0] OP_ZP_INDEXED = 3'd6;

  typedef enum logic {IDLE, FIX} state_t;

  state_t                state;
  logic [AW-1:0]         pc;
  logic [DATA_WIDTH-1:0] sp;
  logic [AW-1:0]         fix_addr;
  logic                  fix_cross;
  logic                  fix_branch;

  logic [DATA_WIDTH-1:0] pc_high;
  logic [DATA_WIDTH-1:0] pc_low;
  logic [AW-1:0]         pc_inc;
  logic [DATA_WIDTH-1:0] sp_inc;
  logic [DATA_WIDTH-1:0] sp_dec;
  logic [DATA_WIDTH:0]   idx_sum;
  logic                  idx_carry;
  logic [DATA_WIDTH-1:0] idx_low;
  logic [DATA_WIDTH-1:0] idx_high_fix;
  logic [DATA_WIDTH:0]   br_sum;
  logic                  br_carry;
  logic [DATA_WIDTH-1:0] br_low;
  logic                  br_up;
  logic                  br_down;
  logic [DATA_WIDTH-1:0] br_high_fix;

  assign pc_high      = pc[AW-1:DATA_WIDTH];
  assign pc_low       = pc[DATA_WIDTH-1:0];
  assign pc_inc       = pc + AW'(1);
  assign sp_inc       = sp + DATA_WIDTH'(1);
  assign sp_dec       = sp - DATA_WIDTH'(1);

  assign idx_sum      = {1'b0, base_low} + {1'b0, index};
  assign idx_carry    = idx_sum[DATA_WIDTH];
  assign idx_low      = idx_sum[DATA_WIDTH-1:0];
  assign idx_high_fix = base_high + {{(DATA_WIDTH-1){1'b0}}, idx_carry};

  // The offset is signed, so the carry out of the low byte only means a page
  // crossing when it disagrees with the offset sign.
  assign br_sum       = {1'b0, pc_low} + {1'b0, offset};
  assign br_carry     = br_sum[DATA_WIDTH];
  assign br_low       = br_sum[DATA_WIDTH-1:0];
  assign br_up        = !offset[DATA_WIDTH-1] && br_carry;
  assign br_down      = offset[DATA_WIDTH-1] && !br_carry;
  assign br_high_fix  = br_up   ? pc_high + DATA_WIDTH'(1) :
                        br_down ? pc_high - DATA_WIDTH'(1) : pc_high;

  assign op_ready = (state == IDLE);
  assign pc_out   = pc;
  assign sp_out   = sp;

  // Control FSM: accepts ops in IDLE, issues fast results or the uncorrected
  // address, then emits the corrected address from FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= PC_RESET;
      sp            <= SP_RESET;
      result_addr   <= '0;
      partial_valid <= 1'b0;
      result_valid  <= 1'b0;
      page_crossed  <= 1'b0;
      illegal_op    <= 1'b0;
      fix_addr      <= '0;
      fix_cross     <= 1'b0;
      fix_branch    <= 1'b0;
    end else begin
      partial_valid <= 1'b0;
      result_valid  <= 1'b0;
      page_crossed  <= 1'b0;
      illegal_op    <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_PC_INC: begin
                pc           <= pc_inc;
                result_addr  <= pc_inc;
                result_valid <= 1'b1;
              end
              OP_PC_LOAD: begin
                pc           <= {base_high, base_low};
                result_addr  <= {base_high, base_low};
                result_valid <= 1'b1;
              end
              OP_INDEXED: begin
                if (!idx_carry && !force_fix) begin
                  result_addr  <= {base_high, idx_low};
                  result_valid <= 1'b1;
                end else begin
                  result_addr   <= {base_high, idx_low};
                  partial_valid <= 1'b1;
                  fix_addr      <= {idx_high_fix, idx_low};
                  fix_cross     <= idx_carry;
                  fix_branch    <= 1'b0;
                  state         <= FIX;
                end
              end
              OP_BRANCH: begin
                if (!br_up && !br_down) begin
                  pc           <= {pc_high, br_low};
                  result_addr  <= {pc_high, br_low};
                  result_valid <= 1'b1;
                end else begin
                  result_addr   <= {pc_high, br_low};
                  partial_valid <= 1'b1;
                  fix_addr      <= {br_high_fix, br_low};
                  fix_cross     <= 1'b1;
                  fix_branch    <= 1'b1;
                  state         <= FIX;
                end
              end
              OP_PUSH: begin
                sp           <= sp_dec;
                result_addr  <= {STACK_PAGE, sp};
                result_valid <= 1'b1;
              end
              OP_POP: begin
                sp           <= sp_inc;
                result_addr  <= {STACK_PAGE, sp_inc};
                result_valid <= 1'b1;
              end
              OP_ZP_INDEXED: begin
                result_addr  <= {{DATA_WIDTH{1'b0}}, idx_low};
                result_valid <= 1'b1;
              end
              default: begin
                result_addr  <= '0;
                illegal_op   <= 1'b1;
                result_valid <= 1'b1;
              end
            endcase
          end
        end
        FIX: begin
          result_addr  <= fix_addr;
          result_valid <= 1'b1;
          page_crossed <= fix_cross;
          if (fix_branch) begin
            pc <= fix_addr;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_address_generation_unit.sv
// Directed testbench for address_generation_unit with hand-computed vectors.
module tb_address_generation_unit;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic        force_fix;
  logic [7:0]  base_low;
  logic [7:0]  base_high;
  logic [7:0]  index;
  logic [7:0]  offset;
  logic        partial_valid;
  logic        result_valid;
  logic [15:0] result_addr;
  logic        page_crossed;
  logic        illegal_op;
  logic [15:0] pc_out;
  logic [7:0]  sp_out;

  int total = 0;
  int bad   = 0;

  address_generation_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .force_fix(force_fix), .base_low(base_low),
    .base_high(base_high), .index(index), .offset(offset),
    .partial_valid(partial_valid), .result_valid(result_valid),
    .result_addr(result_addr), .page_crossed(page_crossed),
    .illegal_op(illegal_op), .pc_out(pc_out), .sp_out(sp_out)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for exactly one accept edge; returns 1 time unit after it
  task automatic issue(input logic [2:0] op, input logic [15:0] base,
                       input logic [7:0] idx, input logic [7:0] off, input logic ff);
    op_code   = op;
    base_high = base[15:8];
    base_low  = base[7:0];
    index     = idx;
    offset    = off;
    force_fix = ff;
    op_valid  = 1'b1;
    @(posedge clk); #1;
    op_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    op_valid = 1'b0; op_code = 3'd0; force_fix = 1'b0;
    base_low = 8'h00; base_high = 8'h00; index = 8'h00; offset = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++; if (pc_out !== 16'h0000) begin bad++; $display("[TB] FAIL reset_pc got=%h want=0000", pc_out); end
    total++; if (sp_out !== 8'hFF) begin bad++; $display("[TB] FAIL reset_sp got=%h want=ff", sp_out); end
    total++; if (op_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", op_ready); end
    total++; if ({partial_valid, result_valid, page_crossed, illegal_op} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {partial_valid, result_valid, page_crossed, illegal_op}); end
    total++; if (result_addr !== 16'h0000) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0000", result_addr); end
    rst = 1'b0;
  endtask

  task automatic test_indexed_no_cross;
    issue(3'd2, 16'h12F0, 8'h0F, 8'h00, 1'b0);
    total++; if ({partial_valid, result_valid, page_crossed} !== 3'b010) begin bad++; $display("[TB] FAIL idx_fast_flags got=%b want=010", {partial_valid, result_valid, page_crossed}); end
    total++; if (result_addr !== 16'h12FF) begin bad++; $display("[TB] FAIL idx_fast_addr got=%h want=12ff", result_addr); end
    issue(3'd2, 16'h12F0, 8'h0F, 8'h00, 1'b1);
    total++; if ({partial_valid, result_valid, op_ready} !== 3'b100) begin bad++; $display("[TB] FAIL idx_force_partial got=%b want=100", {partial_valid, result_valid, op_ready}); end
    total++; if (result_addr !== 16'h12FF) begin bad++; $display("[TB] FAIL idx_force_paddr got=%h want=12ff", result_addr); end
    @(posedge clk); #1;
    total++; if ({partial_valid, result_valid, page_crossed} !== 3'b010) begin bad++; $display("[TB] FAIL idx_force_final got=%b want=010", {partial_valid, result_valid, page_crossed}); end
    total++; if (result_addr !== 16'h12FF) begin bad++; $display("[TB] FAIL idx_force_faddr got=%h want=12ff", result_addr); end
    @(posedge clk); #1;
    total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL idx_force_pulse got=%b want=0", result_valid); end
  endtask

  task automatic test_indexed_cross;
    // Accept edge T; op_valid stays high with a PC_INC through FIX
    issue(3'd2, 16'h12F0, 8'h20, 8'h00, 1'b0);
    op_valid = 1'b1; op_code = 3'd0;
    total++; if ({partial_valid, result_valid, page_crossed, op_ready} !== 4'b1000) begin bad++; $display("[TB] FAIL cross_partial got=%b want=1000", {partial_valid, result_valid, page_crossed, op_ready}); end
    total++; if (result_addr !== 16'h1210) begin bad++; $display("[TB] FAIL cross_paddr got=%h want=1210", result_addr); end
    @(posedge clk); #1;
    total++; if ({partial_valid, result_valid, page_crossed} !== 3'b011) begin bad++; $display("[TB] FAIL cross_final got=%b want=011", {partial_valid, result_valid, page_crossed}); end
    total++; if (result_addr !== 16'h1310) begin bad++; $display("[TB] FAIL cross_faddr got=%h want=1310", result_addr); end
    total++; if (pc_out !== 16'h0000) begin bad++; $display("[TB] FAIL cross_no_accept_in_fix got=%h want=0000", pc_out); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    total++; if ({result_valid, page_crossed} !== 2'b10) begin bad++; $display("[TB] FAIL cross_held_accept got=%b want=10", {result_valid, page_crossed}); end
    total++; if (result_addr !== 16'h0001 || pc_out !== 16'h0001) begin bad++; $display("[TB] FAIL cross_held_pc got=%h/%h want=0001/0001", result_addr, pc_out); end
  endtask

  task automatic test_branch;
    issue(3'd1, 16'h0480, 8'h00, 8'h00, 1'b0);
    total++; if (result_addr !== 16'h0480 || pc_out !== 16'h0480) begin bad++; $display("[TB] FAIL pc_load got=%h/%h want=0480/0480", result_addr, pc_out); end
    issue(3'd3, 16'h0000, 8'h00, 8'h90, 1'b0);
    total++; if ({partial_valid, result_valid, page_crossed} !== 3'b010) begin bad++; $display("[TB] FAIL br_fast_flags got=%b want=010", {partial_valid, result_valid, page_crossed}); end
    total++; if (result_addr !== 16'h0410 || pc_out !== 16'h0410) begin bad++; $display("[TB] FAIL br_fast_addr got=%h/%h want=0410/0410", result_addr, pc_out); end
    issue(3'd3, 16'h0000, 8'h00, 8'hE0, 1'b0);
    total++; if ({partial_valid, result_valid} !== 2'b10) begin bad++; $display("[TB] FAIL br_fix_partial got=%b want=10", {partial_valid, result_valid}); end
    total++; if (result_addr !== 16'h04F0 || pc_out !== 16'h0410) begin bad++; $display("[TB] FAIL br_fix_paddr got=%h/%h want=04f0/0410", result_addr, pc_out); end
    @(posedge clk); #1;
    total++; if ({partial_valid, result_valid, page_crossed} !== 3'b011) begin bad++; $display("[TB] FAIL br_fix_final got=%b want=011", {partial_valid, result_valid, page_crossed}); end
    total++; if (result_addr !== 16'h03F0 || pc_out !== 16'h03F0) begin bad++; $display("[TB] FAIL br_fix_faddr got=%h/%h want=03f0/03f0", result_addr, pc_out); end
    // Forward branch carrying into the next page: 0x03F0 + 0x20 -> 0x0410
    issue(3'd3, 16'h0000, 8'h00, 8'h20, 1'b0);
    total++; if (result_addr !== 16'h0310 || partial_valid !== 1'b1) begin bad++; $display("[TB] FAIL br_up_partial got=%h/%b want=0310/1", result_addr, partial_valid); end
    @(posedge clk); #1;
    total++; if (result_addr !== 16'h0410 || pc_out !== 16'h0410 || page_crossed !== 1'b1) begin bad++; $display("[TB] FAIL br_up_final got=%h/%h/%b want=0410/0410/1", result_addr, pc_out, page_crossed); end
  endtask

  task automatic test_back_to_back;
    op_code = 3'd0; op_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (result_valid !== 1'b1 || result_addr !== 16'h0411) begin bad++; $display("[TB] FAIL b2b_inc1 got=%b/%h want=1/0411", result_valid, result_addr); end
    @(posedge clk); #1;
    total++; if (result_valid !== 1'b1 || result_addr !== 16'h0412) begin bad++; $display("[TB] FAIL b2b_inc2 got=%b/%h want=1/0412", result_valid, result_addr); end
    op_code = 3'd1; base_high = 8'hFF; base_low = 8'hFF;
    @(posedge clk); #1;
    total++; if (result_valid !== 1'b1 || pc_out !== 16'hFFFF) begin bad++; $display("[TB] FAIL b2b_load got=%b/%h want=1/ffff", result_valid, pc_out); end
    op_code = 3'd0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    total++; if (result_addr !== 16'h0000 || pc_out !== 16'h0000) begin bad++; $display("[TB] FAIL pc_wrap got=%h/%h want=0000/0000", result_addr, pc_out); end
    @(posedge clk); #1;
    total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle got=%b want=0", result_valid); end
  endtask

  task automatic test_stack;
    issue(3'd5, 16'h0000, 8'h00, 8'h00, 1'b0);
    total++; if (result_addr !== 16'h0100 || sp_out !== 8'h00) begin bad++; $display("[TB] FAIL pop_wrap got=%h/%h want=0100/00", result_addr, sp_out); end
    issue(3'd4, 16'h0000, 8'h00, 8'h00, 1'b0);
    total++; if (result_addr !== 16'h0100 || sp_out !== 8'hFF) begin bad++; $display("[TB] FAIL push_wrap got=%h/%h want=0100/ff", result_addr, sp_out); end
    issue(3'd4, 16'h0000, 8'h00, 8'h00, 1'b0);
    total++; if (result_addr !== 16'h01FF || sp_out !== 8'hFE) begin bad++; $display("[TB] FAIL push got=%h/%h want=01ff/fe", result_addr, sp_out); end
    issue(3'd5, 16'h0000, 8'h00, 8'h00, 1'b0);
    total++; if (result_addr !== 16'h01FF || sp_out !== 8'hFF) begin bad++; $display("[TB] FAIL pop got=%h/%h want=01ff/ff", result_addr, sp_out); end
    issue(3'd5, 16'h0000, 8'h00, 8'h00, 1'b0);
    total++; if (result_addr !== 16'h0100 || sp_out !== 8'h00) begin bad++; $display("[TB] FAIL pop_wrap2 got=%h/%h want=0100/00", result_addr, sp_out); end
  endtask

  task automatic test_zp;
    issue(3'd6, 16'hABF0, 8'h20, 8'h00, 1'b0);
    total++; if ({partial_valid, result_valid, page_crossed} !== 3'b010) begin bad++; $display("[TB] FAIL zp_flags got=%b want=010", {partial_valid, result_valid, page_crossed}); end
    total++; if (result_addr !== 16'h0010) begin bad++; $display("[TB] FAIL zp_addr got=%h want=0010", result_addr); end
  endtask

  task automatic test_illegal;
    issue(3'd7, 16'h1234, 8'h11, 8'h22, 1'b0);
    total++; if ({result_valid, illegal_op, page_crossed} !== 3'b110) begin bad++; $display("[TB] FAIL illegal_flags got=%b want=110", {result_valid, illegal_op, page_crossed}); end
    total++; if (result_addr !== 16'h0000 || pc_out !== 16'h0000 || sp_out !== 8'h00) begin bad++; $display("[TB] FAIL illegal_state got=%h/%h/%h want=0000/0000/00", result_addr, pc_out, sp_out); end
    @(posedge clk); #1;
    total++; if ({result_valid, illegal_op} !== 2'b00) begin bad++; $display("[TB] FAIL illegal_pulse got=%b want=00", {result_valid, illegal_op}); end
  endtask

  task automatic test_reset_mid_fix;
    issue(3'd1, 16'h1234, 8'h00, 8'h00, 1'b0);
    issue(3'd2, 16'h12F0, 8'h20, 8'h00, 1'b0);
    total++; if (partial_valid !== 1'b1 || op_ready !== 1'b0) begin bad++; $display("[TB] FAIL midfix_partial got=%b/%b want=1/0", partial_valid, op_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({partial_valid, result_valid, page_crossed, op_ready} !== 4'b0001) begin bad++; $display("[TB] FAIL midfix_flags got=%b want=0001", {partial_valid, result_valid, page_crossed, op_ready}); end
    total++; if (pc_out !== 16'h0000 || sp_out !== 8'hFF || result_addr !== 16'h0000) begin bad++; $display("[TB] FAIL midfix_state got=%h/%h/%h want=0000/ff/0000", pc_out, sp_out, result_addr); end
    @(posedge clk); #1;
    total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL midfix_no_result got=%b want=0", result_valid); end
    issue(3'd6, 16'h00F0, 8'h20, 8'h00, 1'b0);
    total++; if (result_addr !== 16'h0010 || page_crossed !== 1'b0 || result_valid !== 1'b1) begin bad++; $display("[TB] FAIL midfix_zp got=%h/%b/%b want=0010/0/1", result_addr, page_crossed, result_valid); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_indexed_no_cross();
    test_indexed_cross();
    test_branch();
    test_back_to_back();
    test_stack();
    test_zp();
    test_illegal();
    test_reset_mid_fix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
